mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data round-robin arbiter in front of a single fixed-latency memory port.
// Latency: request sampled in IDLE -> ack MEM_LATENCY+1 cycles later; one transaction in flight.
// Backpressure: i_stall/d_stall stay high while a request is pending and not yet acked.
module mem_arbiter #(
   parameter int ADDRESS_SIZE = 32,
   parameter int MEM_LATENCY  = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_req,
   input  logic [ADDRESS_SIZE-1:0] i_addr,
   output logic [ADDRESS_SIZE-1:0] i_rdata,
   output logic                    i_ack,
   output logic                    i_stall,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDRESS_SIZE-1:0] d_addr,
   input  logic [ADDRESS_SIZE-1:0] d_wdata,
   output logic [ADDRESS_SIZE-1:0] d_rdata,
   output logic                    d_ack,
   output logic                    d_stall,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDRESS_SIZE-1:0] mem_addr,
   output logic [ADDRESS_SIZE-1:0] mem_wdata,
   input  logic [ADDRESS_SIZE-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   typedef struct packed {
      logic                    we;
      logic [ADDRESS_SIZE-1:0] addr;
      logic [ADDRESS_SIZE-1:0] wdata;
   } req_t;

   localparam logic [7:0] LAT_INIT = 8'(MEM_LATENCY);

   state_t                  state_q;
   state_t                  state_d;
   logic [7:0]              cnt_q;
   owner_t                  last_grant_q;
   owner_t                  owner_q;
   logic                    we_q;
   logic                    mem_req_q;
   req_t                    issue_q;
   logic [ADDRESS_SIZE-1:0] rdata_q;

   logic                    grant;
   owner_t                  grant_owner;
   req_t                    grant_req;
   logic                    last_busy;
   logic                    resp_i;
   logic                    resp_d;

   assign last_busy = (state_q == BUSY) && (cnt_q == 8'd1);

   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      grant_owner = OWN_I;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               grant   = 1'b1;
               state_d = BUSY;
               // on a tie the requester that did not win last time goes first
               if (i_req && d_req) begin
                  if (last_grant_q == OWN_I) grant_owner = OWN_D;
                  else                       grant_owner = OWN_I;
               end else if (d_req) begin
                  grant_owner = OWN_D;
               end
            end
         end
         BUSY: begin
            if (last_busy) state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // instruction fetches are always reads with no write data
   always_comb begin
      grant_req = '0;
      if (grant_owner == OWN_D) begin
         grant_req.we    = d_we;
         grant_req.addr  = d_addr;
         grant_req.wdata = d_wdata;
      end else begin
         grant_req.addr  = i_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         last_grant_q <= OWN_I;
         owner_q      <= OWN_I;
         we_q         <= 1'b0;
         mem_req_q    <= 1'b0;
         issue_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= grant;
         issue_q   <= grant ? grant_req : '0;
         if (grant) begin
            owner_q      <= grant_owner;
            last_grant_q <= grant_owner;
            we_q         <= grant_req.we;
            cnt_q        <= LAT_INIT;
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - 8'd1;
         end
         // a write has nothing to return, so its response word is forced to zero
         if (last_busy) begin
            rdata_q <= we_q ? '0 : mem_rdata;
         end
      end
   end

   assign resp_i = (state_q == RESP) && (owner_q == OWN_I);
   assign resp_d = (state_q == RESP) && (owner_q == OWN_D);

   assign i_ack   = resp_i;
   assign i_rdata = resp_i ? rdata_q : '0;
   assign i_stall = i_req & ~i_ack;

   assign d_ack   = resp_d;
   assign d_rdata = resp_d ? rdata_q : '0;
   assign d_stall = d_req & ~d_ack;

   assign mem_req   = mem_req_q;
   assign mem_we    = issue_q.we;
   assign mem_addr  = issue_q.addr;
   assign mem_wdata = issue_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline model of the single in-flight transaction checked every cycle,
// plus literal cycle/value checks for the fixed scenarios and a randomized requester phase.
module tb_mem_arbiter;
   localparam int AW  = 32;
   localparam int LAT = 5;
   localparam logic [AW-1:0] IA = 32'h0000_1000;
   localparam logic [AW-1:0] DA = 32'h0000_3000;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          i_req     = 1'b0;
   logic          d_req     = 1'b0;
   logic          d_we      = 1'b0;
   logic [AW-1:0] i_addr    = '0;
   logic [AW-1:0] d_addr    = '0;
   logic [AW-1:0] d_wdata   = '0;
   logic [AW-1:0] mem_rdata = '0;
   logic [AW-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic          i_ack, i_stall, d_ack, d_stall, mem_req, mem_we;

   mem_arbiter #(.ADDRESS_SIZE(AW), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t0      = 0;
   bit chk_en  = 0;
   bit r_ia    = 0;
   bit r_da    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic record(input bit ok, input string name, input string got, input string want);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %s, expected %s", name, cyc, got, want);
      end
   endtask

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      record(act === exp, name, $sformatf("0x%0h", act), $sformatf("0x%0h", exp));
   endtask

   task automatic checkb(input string name, input logic act, input logic exp);
      record(act === exp, name, $sformatf("%b", act), $sformatf("%b", exp));
   endtask

   task automatic checki(input string name, input int act, input int exp);
      record(act == exp, name, $sformatf("%0d", act), $sformatf("%0d", exp));
   endtask

   // ---------------- observation logs for the literal scenario checks ----------------
   typedef struct { int c; logic we; logic [AW-1:0] a; logic [AW-1:0] w; } issue_t;
   typedef struct { int c; logic [AW-1:0] d; } ack_t;
   issue_t mreq_log[$];
   ack_t   iack_log[$];
   ack_t   dack_log[$];
   int     istall_log[$];

   function automatic int mq_c(int i);
      return (i < mreq_log.size()) ? mreq_log[i].c - t0 : -1;
   endfunction
   function automatic logic [AW-1:0] mq_a(int i);
      return (i < mreq_log.size()) ? mreq_log[i].a : 'x;
   endfunction
   function automatic logic [AW-1:0] mq_w(int i);
      return (i < mreq_log.size()) ? mreq_log[i].w : 'x;
   endfunction
   function automatic logic mq_we(int i);
      return (i < mreq_log.size()) ? mreq_log[i].we : 1'bx;
   endfunction
   function automatic int ia_c(int i);
      return (i < iack_log.size()) ? iack_log[i].c - t0 : -1;
   endfunction
   function automatic logic [AW-1:0] ia_d(int i);
      return (i < iack_log.size()) ? iack_log[i].d : 'x;
   endfunction
   function automatic int da_c(int i);
      return (i < dack_log.size()) ? dack_log[i].c - t0 : -1;
   endfunction
   function automatic logic [AW-1:0] da_d(int i);
      return (i < dack_log.size()) ? dack_log[i].d : 'x;
   endfunction

   // ---------------- reference model: one transaction on an absolute-cycle timeline ----------------
   bit            m_busy   = 0;
   bit            m_last_d = 0;
   bit            m_own_d  = 0;
   bit            m_we     = 0;
   logic [AW-1:0] m_addr   = '0;
   logic [AW-1:0] m_wdata  = '0;
   logic [AW-1:0] m_rdata  = '0;
   int            m_issue  = 0;
   int            m_ack    = 0;
   bit            x_mreq, x_iack, x_dack;

   always @(negedge clk) begin
      x_mreq = m_busy && (cyc == m_issue);
      x_iack = m_busy && (cyc == m_ack) && !m_own_d;
      x_dack = m_busy && (cyc == m_ack) && m_own_d;
      if (chk_en) begin
         checkb("mem_req",   mem_req,   x_mreq);
         checkb("mem_we",    mem_we,    x_mreq && m_we);
         check ("mem_addr",  mem_addr,  x_mreq ? m_addr  : '0);
         check ("mem_wdata", mem_wdata, x_mreq ? m_wdata : '0);
         checkb("i_ack",     i_ack,     x_iack);
         checkb("d_ack",     d_ack,     x_dack);
         check ("i_rdata",   i_rdata,   x_iack ? m_rdata : '0);
         check ("d_rdata",   d_rdata,   x_dack ? m_rdata : '0);
         checkb("i_stall",   i_stall,   i_req && !x_iack);
         checkb("d_stall",   d_stall,   d_req && !x_dack);
      end
      if (mem_req === 1'b1) mreq_log.push_back('{cyc, mem_we, mem_addr, mem_wdata});
      if (i_ack === 1'b1)   iack_log.push_back('{cyc, i_rdata});
      if (d_ack === 1'b1)   dack_log.push_back('{cyc, d_rdata});
      if (i_stall === 1'b1) istall_log.push_back(cyc);
      // advance across the coming clock edge
      if (reset !== 1'b1) begin
         m_busy   = 0;
         m_last_d = 0;
      end else if (m_busy) begin
         if (cyc == m_ack - 1) m_rdata = m_we ? '0 : mem_rdata;
         if (cyc == m_ack)     m_busy  = 0;
      end else if (i_req || d_req) begin
         m_own_d  = d_req && !(i_req && m_last_d);
         m_last_d = m_own_d;
         m_we     = m_own_d && d_we;
         m_addr   = m_own_d ? d_addr : i_addr;
         m_wdata  = m_own_d ? d_wdata : '0;
         m_issue  = cyc + 1;
         m_ack    = cyc + 1 + LAT;
         m_busy   = 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      checkb({tag, "_mem_req"},   mem_req,   1'b0);
      checkb({tag, "_mem_we"},    mem_we,    1'b0);
      check ({tag, "_mem_addr"},  mem_addr,  '0);
      check ({tag, "_mem_wdata"}, mem_wdata, '0);
      checkb({tag, "_i_ack"},     i_ack,     1'b0);
      checkb({tag, "_d_ack"},     d_ack,     1'b0);
      check ({tag, "_i_rdata"},   i_rdata,   '0);
      check ({tag, "_d_rdata"},   d_rdata,   '0);
      checkb({tag, "_i_stall"},   i_stall,   1'b0);
      checkb({tag, "_d_stall"},   d_stall,   1'b0);
   endtask

   // leaves the bench at the start of an IDLE cycle with empty logs; that cycle is t0
   task automatic apply_reset();
      reset = 0; i_req = 0; d_req = 0; d_we = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      tick();
      tick();
      chk_en = 1;
      reset  = 1;
      @(negedge clk);
      all_zero("rst");
      tick();
      mreq_log.delete();
      iack_log.delete();
      dack_log.delete();
      istall_log.delete();
      t0 = cyc;
   endtask

   initial begin
      // single fetch read
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         i_req = (k <= 6); i_addr = IA;
         mem_rdata = (k == 5) ? 32'hDEADBEEF : $urandom;
         tick();
      end
      checki("rd_n_issue",    mreq_log.size(), 1);
      checki("rd_issue_cyc",  mq_c(0), 1);
      check ("rd_issue_addr", mq_a(0), IA);
      checki("rd_n_ack",      iack_log.size(), 1);
      checki("rd_ack_cyc",    ia_c(0), 6);
      check ("rd_ack_data",   ia_d(0), 32'hDEADBEEF);
      checki("rd_stall_len",  istall_log.size(), 6);
      checki("rd_stall_first", (istall_log.size() > 0) ? istall_log[0] - t0 : -1, 0);
      checki("rd_stall_last",  (istall_log.size() > 0) ? istall_log[istall_log.size()-1] - t0 : -1, 5);

      // tie right after reset: D first, then I
      apply_reset();
      for (int k = 0; k < 16; k++) begin
         i_req = (k <= 13); i_addr = IA;
         d_req = (k <= 6);  d_addr = DA; d_we = 0;
         mem_rdata = $urandom;
         tick();
      end
      checki("tie_n_issue",  mreq_log.size(), 2);
      checki("tie_d_issue",  mq_c(0), 1);
      check ("tie_d_addr",   mq_a(0), DA);
      checki("tie_i_issue",  mq_c(1), 8);
      check ("tie_i_addr",   mq_a(1), IA);
      checki("tie_d_ack",    da_c(0), 6);
      checki("tie_i_ack",    ia_c(0), 13);

      // both held continuously: strict alternation every 7 cycles
      apply_reset();
      for (int k = 0; k < 30; k++) begin
         i_req = 1; i_addr = IA;
         d_req = 1; d_addr = DA; d_we = 0;
         mem_rdata = $urandom;
         tick();
      end
      for (int g = 0; g < 4; g++) begin
         checki($sformatf("alt_issue%0d_cyc", g), mq_c(g), 1 + 7 * g);
         check ($sformatf("alt_issue%0d_addr", g), mq_a(g), (g % 2 == 1) ? IA : DA);
      end
      checki("alt_d_ack0", da_c(0), 6);
      checki("alt_i_ack0", ia_c(0), 13);
      checki("alt_d_ack1", da_c(1), 20);
      checki("alt_i_ack1", ia_c(1), 27);

      // data write
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         d_req = (k <= 6); d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678;
         mem_rdata = (k == 5) ? 32'hFFFFFFFF : $urandom;
         tick();
      end
      checki("wr_issue_cyc",  mq_c(0), 1);
      checkb("wr_issue_we",   mq_we(0), 1'b1);
      check ("wr_issue_addr", mq_a(0), 32'h2000);
      check ("wr_issue_data", mq_w(0), 32'h12345678);
      checki("wr_ack_cyc",    da_c(0), 6);
      check ("wr_ack_data",   da_d(0), '0);
      d_we = 0;

      // reset in cycle 3 of a fetch; then a data read proves arbitration restarted
      apply_reset();
      for (int k = 0; k < 14; k++) begin
         reset = (k != 3);
         i_req = (k < 3); i_addr = IA;
         d_req = (k >= 5 && k <= 11); d_addr = DA; d_we = 0;
         mem_rdata = $urandom;
         if (k == 4) begin
            @(negedge clk);
            all_zero("mid_rst");
         end
         tick();
      end
      checki("mid_rst_n_iack",  iack_log.size(), 0);
      checki("mid_rst_n_issue", mreq_log.size(), 2);
      checki("mid_rst_issue0",  mq_c(0), 1);
      checki("mid_rst_issue1",  mq_c(1), 6);
      check ("mid_rst_addr1",   mq_a(1), DA);
      checki("mid_rst_d_ack",   da_c(0), 11);

      // fetch request dropped early still completes, and is not reissued
      apply_reset();
      for (int k = 0; k < 12; k++) begin
         i_req = (k < 2); i_addr = IA;
         mem_rdata = (k == 5) ? 32'hCAFEF00D : $urandom;
         tick();
      end
      checki("drop_n_issue", mreq_log.size(), 1);
      checki("drop_n_ack",   iack_log.size(), 1);
      checki("drop_ack_cyc", ia_c(0), 6);
      check ("drop_ack_data", ia_d(0), 32'hCAFEF00D);

      // randomized requesters, occasional early drops and resets
      apply_reset();
      r_ia = 0;
      r_da = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset = 0; i_req = 0; d_req = 0;
         end else begin
            reset = 1;
            if (r_ia || !i_req || $urandom_range(0, 39) == 0) begin
               i_req  = ($urandom_range(0, 2) != 0);
               i_addr = $urandom;
            end
            if (r_da || !d_req || $urandom_range(0, 39) == 0) begin
               d_req   = ($urandom_range(0, 2) != 0);
               d_we    = $urandom_range(0, 1);
               d_addr  = $urandom;
               d_wdata = $urandom;
            end
         end
         mem_rdata = $urandom;
         r_ia = (i_ack === 1'b1);
         r_da = (d_ack === 1'b1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
